// File: rtl/dct_rowbuf_pp.sv
// dct_rowbuf_pp
// Row buffer between the CX multiply-accumulate stage and the transpose stage.
// Words arrive one per cycle into staging slots 0..NUM_ENT-2; a write to the
// last slot commits the staged words plus that last word to the held parallel
// output qr in a single cycle, under a valid/ready handshake. Data is stored
// bit-exact with no arithmetic.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   enreg      write strobe for din
//   wa         write slot (used when AUTO_ADDR == 0)
//   din        write data
//   wr_ready   combinational: a last-slot write would be accepted this cycle
//   qr         committed row, entry k at qr[k*WIDTH +: WIDTH]
//   row_valid  qr holds an unconsumed row
//   row_ready  downstream consumes the row
//   wcnt       internal write counter (AUTO_ADDR == 1), otherwise 0
//   ovf        sticky: a last-slot write was dropped
//   row_err    sticky: a row was committed with missing staged entries
//   clr_err    synchronous clear of ovf and row_err (wins over a same-cycle set)

module dct_rowbuf_pp #(
    parameter int unsigned WIDTH     = 11,
    parameter int unsigned NUM_ENT   = 8,
    parameter int unsigned ADDR_W    = 3,
    parameter int unsigned AUTO_ADDR = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       enreg,
    input  logic [ADDR_W-1:0]          wa,
    input  logic [WIDTH-1:0]           din,
    output logic                       wr_ready,
    output logic [NUM_ENT*WIDTH-1:0]   qr,
    output logic                       row_valid,
    input  logic                       row_ready,
    output logic [ADDR_W-1:0]          wcnt,
    output logic                       ovf,
    output logic                       row_err,
    input  logic                       clr_err
);

    localparam int unsigned LAST      = NUM_ENT - 1;
    localparam int unsigned ROW_W     = NUM_ENT * WIDTH;
    localparam logic [ADDR_W-1:0] LAST_SLOT = ADDR_W'(LAST);

    // Staging for all but the last entry; the last entry comes straight from din.
    logic [WIDTH-1:0]  stg_q [LAST];
    logic [LAST-1:0]   mask_q;
    logic [ROW_W-1:0]  qr_q;
    logic              row_valid_q;
    logic [ADDR_W-1:0] wcnt_q;
    logic              ovf_q;
    logic              row_err_q;

    logic [ADDR_W-1:0] slot_c;
    logic              wr_ready_c;
    logic              mid_we_c;
    logic              last_we_c;
    logic              commit_c;
    logic              drop_c;
    logic              consume_c;
    logic              row_full_c;

    // Write decode: slots at or beyond NUM_ENT match neither term and are ignored.
    always_comb begin
        slot_c     = (AUTO_ADDR != 0) ? wcnt_q : wa;
        wr_ready_c = ~row_valid_q | row_ready;
        mid_we_c   = enreg & (slot_c < LAST_SLOT);
        last_we_c  = enreg & (slot_c == LAST_SLOT);
        commit_c   = last_we_c & wr_ready_c;
        drop_c     = last_we_c & ~wr_ready_c;
        consume_c  = row_valid_q & row_ready;
        row_full_c = &mask_q;
    end

    // Staging registers and written-mask; staging ignores output backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < int'(LAST); k++) begin
                stg_q[k] <= '0;
            end
            mask_q <= '0;
        end else begin
            for (int k = 0; k < int'(LAST); k++) begin
                if (mid_we_c && (slot_c == ADDR_W'(k))) begin
                    stg_q[k]  <= din;
                    mask_q[k] <= 1'b1;
                end
            end
            if (commit_c) begin
                mask_q <= '0;
            end
        end
    end

    // Output row: commit wins over consume so a same-cycle pair keeps row_valid high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            qr_q        <= '0;
            row_valid_q <= 1'b0;
        end else if (commit_c) begin
            for (int k = 0; k < int'(LAST); k++) begin
                qr_q[k*WIDTH +: WIDTH] <= stg_q[k];
            end
            qr_q[LAST*WIDTH +: WIDTH] <= din;
            row_valid_q               <= 1'b1;
        end else if (consume_c) begin
            row_valid_q <= 1'b0;
        end
    end

    // Internal write counter; a dropped last-slot write leaves it on the last slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wcnt_q <= '0;
        end else if (AUTO_ADDR != 0) begin
            if (commit_c) begin
                wcnt_q <= '0;
            end else if (mid_we_c) begin
                wcnt_q <= wcnt_q + ADDR_W'(1);
            end
        end
    end

    // Sticky error flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q     <= 1'b0;
            row_err_q <= 1'b0;
        end else if (clr_err) begin
            ovf_q     <= 1'b0;
            row_err_q <= 1'b0;
        end else begin
            if (drop_c) begin
                ovf_q <= 1'b1;
            end
            if (commit_c && !row_full_c) begin
                row_err_q <= 1'b1;
            end
        end
    end

    assign wr_ready  = wr_ready_c;
    assign qr        = qr_q;
    assign row_valid = row_valid_q;
    assign wcnt      = wcnt_q;
    assign ovf       = ovf_q;
    assign row_err   = row_err_q;

endmodule

// File: tb/tb_dct_rowbuf_pp.sv
module tb_dct_rowbuf_pp;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // main instance: defaults (8 entries, external addressing)
    logic        en, rr, ce, wrdy, rv, ovf, rerr;
    logic [2:0]  wa, wcnt;
    logic [10:0] din;
    logic [87:0] qr;

    // auto-address instance: 5 entries
    logic        en_a, rr_a, ce_a, wrdy_a, rv_a, ovf_a, rerr_a;
    logic [2:0]  wa_a, wcnt_a;
    logic [10:0] din_a;
    logic [54:0] qr_a;

    // external-address instance: 5 entries
    logic        en_b, rr_b, ce_b, wrdy_b, rv_b, ovf_b, rerr_b;
    logic [2:0]  wa_b, wcnt_b;
    logic [10:0] din_b;
    logic [54:0] qr_b;

    dct_rowbuf_pp dut (
        .clk(clk), .rst_n(rst_n), .enreg(en), .wa(wa), .din(din), .wr_ready(wrdy),
        .qr(qr), .row_valid(rv), .row_ready(rr), .wcnt(wcnt), .ovf(ovf),
        .row_err(rerr), .clr_err(ce)
    );

    dct_rowbuf_pp #(.WIDTH(11), .NUM_ENT(5), .ADDR_W(3), .AUTO_ADDR(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .enreg(en_a), .wa(wa_a), .din(din_a), .wr_ready(wrdy_a),
        .qr(qr_a), .row_valid(rv_a), .row_ready(rr_a), .wcnt(wcnt_a), .ovf(ovf_a),
        .row_err(rerr_a), .clr_err(ce_a)
    );

    dct_rowbuf_pp #(.WIDTH(11), .NUM_ENT(5), .ADDR_W(3), .AUTO_ADDR(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .enreg(en_b), .wa(wa_b), .din(din_b), .wr_ready(wrdy_b),
        .qr(qr_b), .row_valid(rv_b), .row_ready(rr_b), .wcnt(wcnt_b), .ovf(ovf_b),
        .row_err(rerr_b), .clr_err(ce_b)
    );

    function automatic logic [87:0] row8(input logic [10:0] base);
        logic [87:0] r;
        r = '0;
        for (int k = 0; k < 8; k++) r[k*11 +: 11] = base + 11'(k);
        return r;
    endfunction

    function automatic logic [54:0] row5(input logic [10:0] base);
        logic [54:0] r;
        r = '0;
        for (int k = 0; k < 5; k++) r[k*11 +: 11] = base + 11'(k);
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_m(input logic [2:0] s, input logic [10:0] d);
        en = 1'b1; wa = s; din = d;
        step();
        en = 1'b0;
    endtask

    task automatic wr_a(input logic [2:0] s, input logic [10:0] d);
        en_a = 1'b1; wa_a = s; din_a = d;
        step();
        en_a = 1'b0;
    endtask

    task automatic wr_b(input logic [2:0] s, input logic [10:0] d);
        en_b = 1'b1; wa_b = s; din_b = d;
        step();
        en_b = 1'b0;
    endtask

    task automatic test_reset();
        en = 0; wa = 0; din = 0; rr = 1; ce = 0;
        en_a = 0; wa_a = 0; din_a = 0; rr_a = 1; ce_a = 0;
        en_b = 0; wa_b = 0; din_b = 0; rr_b = 1; ce_b = 0;
        rst_n = 1'b0;
        step(); step();
        rst_n = 1'b1;
        step();
        n_checks++;
        if (qr !== 88'h0 || rv !== 1'b0 || ovf !== 1'b0 || rerr !== 1'b0 || wcnt !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_state: qr=%h rv=%b ovf=%b rerr=%b wcnt=%0d, required all 0", qr, rv, ovf, rerr, wcnt);
        end
    endtask

    task automatic test_basic_row();
        logic [87:0] exp;
        rr = 1;
        for (int k = 0; k < 8; k++) wr_m(3'(k), 11'(k + 1));
        exp = row8(11'h001);
        n_checks++;
        if (rv !== 1'b1 || qr !== exp || rerr !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_commit: rv=%b qr=%h rerr=%b, required rv=1 qr=%h rerr=0", rv, qr, rerr, exp);
        end
        step();
        n_checks++;
        if (rv !== 1'b0 || qr !== exp) begin
            n_fail++;
            $display("FAIL basic_consume: rv=%b qr=%h, required rv=0 qr=%h", rv, qr, exp);
        end
    endtask

    task automatic test_backpressure();
        logic [87:0] exp_a, exp_b;
        exp_a = row8(11'h100);
        exp_b = row8(11'h200);
        rr = 0;
        for (int k = 0; k < 8; k++) wr_m(3'(k), 11'h100 + 11'(k));
        for (int k = 0; k < 7; k++) wr_m(3'(k), 11'h200 + 11'(k));
        en = 1; wa = 3'd7; din = 11'h207;
        #1;
        n_checks++;
        if (wrdy !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_wr_ready: wr_ready=%b, required 0", wrdy);
        end
        step();
        en = 0;
        n_checks++;
        if (ovf !== 1'b1 || rv !== 1'b1 || qr !== exp_a) begin
            n_fail++;
            $display("FAIL bp_drop: ovf=%b rv=%b qr=%h, required ovf=1 rv=1 qr=%h", ovf, rv, qr, exp_a);
        end
        rr = 1;
        wr_m(3'd7, 11'h207);
        n_checks++;
        if (rv !== 1'b1 || qr !== exp_b || ovf !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_retry: rv=%b qr=%h ovf=%b, required rv=1 qr=%h ovf=1", rv, qr, ovf, exp_b);
        end
        ce = 1;
        step();
        ce = 0;
        n_checks++;
        if (ovf !== 1'b0 || rv !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_clear: ovf=%b rv=%b, required ovf=0 rv=0", ovf, rv);
        end
    endtask

    task automatic test_back_to_back();
        logic [87:0] exp_c, exp_d;
        exp_c = row8(11'h300);
        exp_d = row8(11'h380);
        rr = 1;
        for (int k = 0; k < 8; k++) wr_m(3'(k), 11'h300 + 11'(k));
        rr = 0;
        for (int k = 0; k < 7; k++) wr_m(3'(k), 11'h380 + 11'(k));
        n_checks++;
        if (rv !== 1'b1 || qr !== exp_c) begin
            n_fail++;
            $display("FAIL b2b_hold: rv=%b qr=%h, required rv=1 qr=%h", rv, qr, exp_c);
        end
        rr = 1;
        en = 1; wa = 3'd7; din = 11'h387;
        #1;
        n_checks++;
        if (wrdy !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_wr_ready: wr_ready=%b, required 1", wrdy);
        end
        step();
        en = 0;
        n_checks++;
        if (rv !== 1'b1 || qr !== exp_d || ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_switch: rv=%b qr=%h ovf=%b, required rv=1 qr=%h ovf=0", rv, qr, ovf, exp_d);
        end
        step();
        n_checks++;
        if (rv !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_drain: rv=%b, required 0", rv);
        end
    endtask

    task automatic test_missing_entry();
        logic [87:0] exp;
        exp = row8(11'h400);
        exp[6*11 +: 11] = 11'h386;   // stale slot 6 left over from the previous row
        rr = 0;
        for (int k = 0; k < 6; k++) wr_m(3'(k), 11'h400 + 11'(k));
        wr_m(3'd7, 11'h407);
        n_checks++;
        if (rv !== 1'b1 || rerr !== 1'b1 || qr !== exp) begin
            n_fail++;
            $display("FAIL missing_commit: rv=%b rerr=%b qr=%h, required rv=1 rerr=1 qr=%h", rv, rerr, qr, exp);
        end
        // dropped write and clear in the same cycle: clear wins
        en = 1; wa = 3'd7; din = 11'h7FF; ce = 1;
        step();
        en = 0; ce = 0;
        n_checks++;
        if (rerr !== 1'b0 || ovf !== 1'b0 || qr !== exp || rv !== 1'b1) begin
            n_fail++;
            $display("FAIL clr_priority: rerr=%b ovf=%b rv=%b qr=%h, required rerr=0 ovf=0 rv=1 qr=%h", rerr, ovf, rv, qr, exp);
        end
        rr = 1;
        step();
    endtask

    task automatic test_auto_addr();
        for (int i = 0; i < 10; i++) begin
            n_checks++;
            if (wcnt_a !== 3'(i % 5)) begin
                n_fail++;
                $display("FAIL auto_wcnt[%0d]: wcnt=%0d, required %0d", i, wcnt_a, i % 5);
            end
            wr_a(3'($urandom_range(0, 7)), 11'h010 + 11'(i));
            if (i == 4) begin
                n_checks++;
                if (rv_a !== 1'b1 || qr_a !== row5(11'h010) || rerr_a !== 1'b0) begin
                    n_fail++;
                    $display("FAIL auto_row0: rv=%b qr=%h rerr=%b, required rv=1 qr=%h rerr=0", rv_a, qr_a, rerr_a, row5(11'h010));
                end
            end
        end
        n_checks++;
        if (rv_a !== 1'b1 || qr_a !== row5(11'h015) || wcnt_a !== 3'd0 || ovf_a !== 1'b0 || rerr_a !== 1'b0) begin
            n_fail++;
            $display("FAIL auto_row1: rv=%b qr=%h wcnt=%0d ovf=%b rerr=%b, required rv=1 qr=%h wcnt=0 ovf=0 rerr=0",
                     rv_a, qr_a, wcnt_a, ovf_a, rerr_a, row5(11'h015));
        end
    endtask

    task automatic test_out_of_range();
        wr_b(3'd6, 11'h7FF);
        wr_b(3'd5, 11'h7FF);
        wr_b(3'd7, 11'h7FF);
        n_checks++;
        if (rv_b !== 1'b0 || ovf_b !== 1'b0 || rerr_b !== 1'b0 || wcnt_b !== 3'd0) begin
            n_fail++;
            $display("FAIL oor_ignored: rv=%b ovf=%b rerr=%b wcnt=%0d, required all 0", rv_b, ovf_b, rerr_b, wcnt_b);
        end
        for (int k = 0; k < 5; k++) wr_b(3'(k), 11'h050 + 11'(k));
        n_checks++;
        if (rv_b !== 1'b1 || qr_b !== row5(11'h050) || rerr_b !== 1'b0 || ovf_b !== 1'b0) begin
            n_fail++;
            $display("FAIL oor_row: rv=%b qr=%h rerr=%b ovf=%b, required rv=1 qr=%h rerr=0 ovf=0", rv_b, qr_b, rerr_b, ovf_b, row5(11'h050));
        end
    endtask

    task automatic test_mid_reset();
        rr = 0;
        for (int k = 0; k < 8; k++) wr_m(3'(k), 11'h600 + 11'(k));
        for (int k = 0; k < 4; k++) wr_m(3'(k), 11'h680 + 11'(k));
        wr_m(3'd7, 11'h687);
        n_checks++;
        if (ovf !== 1'b1 || rv !== 1'b1) begin
            n_fail++;
            $display("FAIL prereset: ovf=%b rv=%b, required ovf=1 rv=1", ovf, rv);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (qr !== 88'h0 || rv !== 1'b0 || ovf !== 1'b0 || rerr !== 1'b0 || wcnt !== 3'd0) begin
            n_fail++;
            $display("FAIL async_reset: qr=%h rv=%b ovf=%b rerr=%b wcnt=%0d, required all 0", qr, rv, ovf, rerr, wcnt);
        end
        step(); step();
        rst_n = 1'b1;
        rr = 1;
        step();
        for (int k = 0; k < 8; k++) wr_m(3'(k), 11'h700 + 11'(k));
        n_checks++;
        if (rv !== 1'b1 || rerr !== 1'b0 || qr !== row8(11'h700)) begin
            n_fail++;
            $display("FAIL post_reset_row: rv=%b rerr=%b qr=%h, required rv=1 rerr=0 qr=%h", rv, rerr, qr, row8(11'h700));
        end
    endtask

    initial begin
        test_reset();
        test_basic_row();
        test_backpressure();
        test_back_to_back();
        test_missing_entry();
        test_auto_addr();
        test_out_of_range();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
